// File: rtl/pc_sequencer_pkg.sv
// Shared constants and FSM encoding for the program-counter sequencer.
// Optional statistics counters are enabled with the PC_SEQ_STATS_EN macro.
package pc_sequencer_pkg;

    localparam logic [1:0] JSEL_NONE = 2'b00;
    localparam logic [1:0] JSEL_JAL  = 2'b01;
    localparam logic [1:0] JSEL_JALR = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_ADDR = 32'h0000_006c;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between hazard unit / EX stage, the sequencer and the fetch port.
// Counter outputs exist only when PC_SEQ_STATS_EN is defined.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    // ex_valid qualifies every ex_* field; there is no back-pressure, a valid
    // redirect is consumed in the cycle it is presented. fetch_valid qualifies
    // pc towards instruction memory, which must accept it unconditionally.
    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_jump_sel;
    logic        ex_branch_taken;
    logic [31:0] ex_pc_imm;
    logic [31:0] ex_rs1_imm;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic        trap;
    logic [31:0] trap_addr;
    pc_state_e   state;
`ifdef PC_SEQ_STATS_EN
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    modport slave (
        input  stall, ex_valid, ex_jump_sel, ex_branch_taken, ex_pc_imm, ex_rs1_imm,
        output pc, fetch_valid, flush_if_id, flush_id_ex, halted, trap, trap_addr, state
`ifdef PC_SEQ_STATS_EN
        , output redirect_cnt, stall_cnt
`endif
    );

    modport master (
        output stall, ex_valid, ex_jump_sel, ex_branch_taken, ex_pc_imm, ex_rs1_imm,
        input  pc, fetch_valid, flush_if_id, flush_id_ex, halted, trap, trap_addr, state
`ifdef PC_SEQ_STATS_EN
        , input redirect_cnt, stall_cnt
`endif
    );

endinterface

// File: rtl/pc_target_sel.sv
// Combinational redirect detection and target selection from EX-stage results.
module pc_target_sel
    import pc_sequencer_pkg::*;
(
    input  logic        ex_valid_i,
    input  logic [1:0]  ex_jump_sel_i,
    input  logic        ex_branch_taken_i,
    input  logic [31:0] ex_pc_imm_i,
    input  logic [31:0] ex_rs1_imm_i,
    output logic        redir_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    always_comb begin
        redir_o  = ex_valid_i & ((ex_jump_sel_i == JSEL_JAL) | (ex_jump_sel_i == JSEL_JALR)
                                 | ex_branch_taken_i);
        target_o = ex_pc_imm_i;
        // jal outranks jalr, which outranks a taken branch
        if (ex_jump_sel_i == JSEL_JALR) begin
            target_o = ex_rs1_imm_i & ~32'h1;
        end
        misalign_o = target_o[1];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter register and RUN/HALT/TRAP sequencing for the fetch stage.
// Define PC_SEQ_STATS_EN to add saturating redirect and stall counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] HALT_ADDR = DEF_HALT_ADDR
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] trap_addr_q, trap_addr_d;
    logic        redir;
    logic        misalign;
    logic [31:0] target;

    pc_target_sel u_target_sel (
        .ex_valid_i        (bus.ex_valid),
        .ex_jump_sel_i     (bus.ex_jump_sel),
        .ex_branch_taken_i (bus.ex_branch_taken),
        .ex_pc_imm_i       (bus.ex_pc_imm),
        .ex_rs1_imm_i      (bus.ex_rs1_imm),
        .redir_o           (redir),
        .target_o          (target),
        .misalign_o        (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            trap_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_addr_d = trap_addr_q;
        case (state_q)
            RUN: begin
                // EX is older than the stall source, so a redirect beats stall
                if (redir && misalign) begin
                    state_d     = TRAP;
                    trap_addr_d = target;
                end else if (redir) begin
                    pc_d = target;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (pc_q == HALT_ADDR) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HALT: begin
                if (redir && misalign) begin
                    state_d     = TRAP;
                    trap_addr_d = target;
                end else if (redir) begin
                    state_d = RUN;
                    pc_d    = target;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = (state_q == RUN) & ~bus.stall;
    assign bus.flush_if_id = redir & (state_q != TRAP);
    assign bus.flush_id_ex = redir & (state_q != TRAP);
    assign bus.halted      = (state_q == HALT);
    assign bus.trap        = (state_q == TRAP);
    assign bus.trap_addr   = trap_addr_q;
    assign bus.state       = state_q;

`ifdef PC_SEQ_STATS_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        redir_acc;
    logic        stall_cyc;

    assign redir_acc = redir & (state_q != TRAP);
    assign stall_cyc = (state_q == RUN) & bus.stall & ~redir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_cnt_q <= 32'h0;
            stall_cnt_q    <= 32'h0;
        end else begin
            if (redir_acc && redirect_cnt_q != 32'hFFFF_FFFF) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if (stall_cyc && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: cycle model feeds an expected queue.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int W = 71;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] m_pc;
    logic [31:0] m_taddr;
    pc_state_e   m_state;
    logic [31:0] m_rcnt;
    logic [31:0] m_scnt;
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_redir();
        return bus.ex_valid && (bus.ex_jump_sel == 2'b01 || bus.ex_jump_sel == 2'b10
                                || bus.ex_branch_taken);
    endfunction

    function automatic logic [31:0] m_target();
        if (bus.ex_jump_sel == 2'b01) return bus.ex_pc_imm;
        if (bus.ex_jump_sel == 2'b10) return {bus.ex_rs1_imm[31:1], 1'b0};
        return bus.ex_pc_imm;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_taddr = 32'h0;
        m_state = RUN;
        m_rcnt  = 32'h0;
        m_scnt  = 32'h0;
    endtask

    task automatic model_edge();
        logic        r;
        logic [31:0] t;
        if (!rst_n) begin
            model_reset();
        end else begin
            r = m_redir();
            t = m_target();
            if (r && m_state != TRAP && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 1;
            if (m_state == RUN && bus.stall && !r && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            case (m_state)
                RUN: begin
                    if (r && t[1]) begin
                        m_state = TRAP;
                        m_taddr = t;
                    end else if (r) begin
                        m_pc = t;
                    end else if (!bus.stall) begin
                        if (m_pc == 32'h6c) m_state = HALT;
                        else m_pc = m_pc + 32'd4;
                    end
                end
                HALT: begin
                    if (r && t[1]) begin
                        m_state = TRAP;
                        m_taddr = t;
                    end else if (r) begin
                        m_state = RUN;
                        m_pc    = t;
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    // One clock: drive after the edge, compare at negedge, advance the model at the edge.
    task automatic drive(input logic s, input logic v, input logic [1:0] js, input logic bt,
                         input logic [31:0] pimm, input logic [31:0] rimm, input logic rn);
        logic [W-1:0] e;
        logic         fl;
        bus.stall           = s;
        bus.ex_valid        = v;
        bus.ex_jump_sel     = js;
        bus.ex_branch_taken = bt;
        bus.ex_pc_imm       = pimm;
        bus.ex_rs1_imm      = rimm;
        rst_n               = rn;
        fl = m_redir() && m_state != TRAP;
        exp_q.push_back({m_pc, m_taddr, (m_state == RUN) && !s, fl, fl,
                         m_state == HALT, m_state == TRAP, m_state});
        @(negedge clk);
        e = exp_q.pop_front();
        check("pc",          bus.pc,                  e[70:39]);
        check("trap_addr",   bus.trap_addr,           e[38:7]);
        check("fetch_valid", 32'(bus.fetch_valid),    32'(e[6]));
        check("flush_if_id", 32'(bus.flush_if_id),    32'(e[5]));
        check("flush_id_ex", 32'(bus.flush_id_ex),    32'(e[4]));
        check("halted",      32'(bus.halted),         32'(e[3]));
        check("trap",        32'(bus.trap),           32'(e[2]));
        check("state",       32'(bus.state),          32'(e[1:0]));
`ifdef PC_SEQ_STATS_EN
        check("redirect_cnt", bus.redirect_cnt, m_rcnt);
        check("stall_cnt",    bus.stall_cnt,    m_scnt);
`endif
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic stall_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic jal(input logic [31:0] t);
        drive(1'b0, 1'b1, 2'b01, 1'b0, t, 32'h0, 1'b1);
    endtask

    task automatic jalr(input logic [31:0] r);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, r, 1'b1);
    endtask

    task automatic reset_cycle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_jump_sel = 2'b00;
        bus.ex_branch_taken = 1'b0; bus.ex_pc_imm = 32'h0; bus.ex_rs1_imm = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        check("rst_pc",     bus.pc,               32'h0);
        check("rst_trap",   32'(bus.trap),        32'h0);
        check("rst_halted", 32'(bus.halted),      32'h0);
        check("rst_taddr",  bus.trap_addr,        32'h0);

        idle(4);                                              // pc 0,4,8,C
        stall_n(2);                                           // pc holds at 10
        drive(1'b1, 1'b1, 2'b00, 1'b1, 32'h40, 32'h0, 1'b1);  // branch beats stall
        check("branch_pc", bus.pc, 32'h40);
        jalr(32'h81);
        check("jalr_pc", bus.pc, 32'h80);
        idle(1);
        jalr(32'h82);                                         // misaligned -> TRAP
        idle(1);
        jal(32'h100);                                         // no flush in TRAP
        check("trap_addr_hold", bus.trap_addr, 32'h82);
        reset_cycle();
        check("trap_reset_pc", bus.pc, 32'h0);

        idle(28);                                             // 0..6C, then HALT
        check("halt_pc", bus.pc, 32'h6c);
        idle(1);
        stall_n(1);
        jal(32'h20);                                          // leave HALT
        check("halt_exit_pc", bus.pc, 32'h20);
        jal(32'hFFFF_FFFC);
        idle(2);                                              // wraps to 0
        jal(32'h6c);
        drive(1'b0, 1'b1, 2'b00, 1'b1, 32'h100, 32'h0, 1'b1); // branch at HALT_ADDR
        check("branch_at_halt", bus.pc, 32'h100);
        drive(1'b0, 1'b1, 2'b11, 1'b0, 32'h200, 32'h0, 1'b1); // jsel 11 is no jump
        drive(1'b0, 1'b1, 2'b11, 1'b1, 32'h200, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 1'b1); // bubble in EX
        drive(1'b0, 1'b1, 2'b01, 1'b1, 32'h48, 32'h9, 1'b1);  // jal beats branch
        drive(1'b0, 1'b1, 2'b10, 1'b1, 32'h48, 32'h51, 1'b1); // jalr beats branch
        jal(32'h6c);
        idle(2);
        jal(32'h22);                                          // misaligned from HALT
        idle(1);

        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 1) * 2),
                  32'($urandom_range(0, 1023)), 1'($urandom_range(0, 15) != 0));
        end

        reset_cycle();
        stall_n(5);
        jal(32'h200);
        jal(32'h300);
        jal(32'h400);
`ifdef PC_SEQ_STATS_EN
        check("stats_redirects", bus.redirect_cnt, 32'd3);
        check("stats_stalls",    bus.stall_cnt,    32'd5);
        reset_cycle();
        check("stats_clr_redir", bus.redirect_cnt, 32'd0);
        check("stats_clr_stall", bus.stall_cnt,    32'd0);
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register for the five-stage pipeline and drives the fetch address each cycle.
- Arbitrates between sequential fetch, EX-stage redirects (jal, jalr, taken branch) and hazard-unit stalls.
- Asserts pipeline flushes on a redirect and manages the halt (self-loop) and misaligned-target trap states.
- Sits between the hazard unit / EX stage and the instruction-memory fetch port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_ADDR, 32'h0000_006c, fetch address that marks end of program (self-loop).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hazard unit: hold PC and fetch
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_jump_sel  in  2  01 = jal (target pc_imm), 10 = jalr (target rs1_imm), 00/11 = none
- ex_branch_taken  in  1  conditional branch resolved taken (target pc_imm)
- ex_pc_imm  in  32  pc + immediate from EX
- ex_rs1_imm  in  32  rs1 + immediate from EX
- pc  out  32  current fetch address
- fetch_valid  out  1  instruction memory read is meaningful this cycle
- flush_if_id  out  1  kill IF/ID contents at next edge
- flush_id_ex  out  1  kill ID/EX contents at next edge
- halted  out  1  sequencer in HALT state
- trap  out  1  sequencer in TRAP state (misaligned target)
- trap_addr  out  32  offending target address

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low; the polarity and synchronicity are fixed.
- Reset (rst_n = 0 at edge): pc = RESET_PC, state = RUN, trap_addr = 0, halted = 0, trap = 0. Reset overrides every other input, including mid-redirect and mid-HALT/TRAP.
- Redirect request (combinational): redir = ex_valid & (ex_jump_sel == 01 | ex_jump_sel == 10 | ex_branch_taken).
- Redirect target: jal → ex_pc_imm; jalr → {ex_rs1_imm[31:1], 1'b0}; branch → ex_pc_imm. Priority is jal > jalr > branch.
- flush_if_id = flush_id_ex = redir & state != TRAP. Both are combinational, same cycle as the redirect.
- FSM states: RUN, HALT, TRAP.
- RUN, per edge, priority order:
  - redir with target[1] = 1 → TRAP, trap_addr = target, pc unchanged.
  - redir → pc = target (stall ignored; EX is older than the stall source).
  - stall → pc held.
  - pc == HALT_ADDR → HALT, pc held.
  - else → pc = pc + 4, wrapping mod 2^32 (FFFF_FFFC → 0).
- HALT: pc frozen, fetch_valid = 0, halted = 1. A redir (older in-flight branch) is still honoured with the same target and misalignment rules and returns the FSM to RUN. stall has no effect.
- TRAP: pc frozen, fetch_valid = 0, trap = 1, no flushes. Exit only by reset.
- fetch_valid = (state == RUN) & ~stall.
- Latency: a redirect presented in cycle N gives pc = target in cycle N+1.
- Branch resolved at a HALT_ADDR fetch: redirect wins, HALT is not entered.
- ex_jump_sel = 11 is treated as no jump; only ex_branch_taken is considered.

Optional Feature:
- Macro PC_SEQ_STATS_EN.
- Defined: adds outputs redirect_cnt[31:0] and stall_cnt[31:0].
  - redirect_cnt increments on each accepted redirect.
  - stall_cnt increments on each RUN cycle with stall = 1 and no redirect.
  - Both saturate at FFFF_FFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - jump-select constants JSEL_NONE = 2'b00, JSEL_JAL = 2'b01, JSEL_JALR = 2'b10;
  - FSM state encoding typedef (RUN = 0, HALT = 1, TRAP = 2);
  - default RESET_PC and HALT_ADDR constants.
- One natural sub-module, pc_target_sel: combinational redir and target generation plus the misalign flag. The FSM and PC register stay in pc_sequencer.

Test Plan:
- Reset then 4 free-running cycles → pc 0, 4, 8, C; fetch_valid = 1; no flushes.
- At pc = 10: stall for 2 cycles, then ex_valid = 1 with ex_branch_taken = 1 and ex_pc_imm = 40 while stall = 1 → pc holds at 10 for 2 cycles; in the redirect cycle both flushes = 1; next cycle pc = 40.
- jalr with ex_rs1_imm = 81 → pc = 80 next cycle. jalr with ex_rs1_imm = 82 → TRAP, trap = 1, trap_addr = 82, pc frozen; rst_n = 0 → pc = 0, trap = 0.
- Run until pc = 6C → HALT, halted = 1, fetch_valid = 0, pc stays 6C. Then a jal redirect with ex_pc_imm = 20 → RUN, pc = 20.
- Force pc = FFFF_FFFC via redirect, no stall → next pc = 0000_0000.
- With PC_SEQ_STATS_EN defined: 3 redirects and 5 stall cycles → redirect_cnt = 3, stall_cnt = 5; both clear on reset.
